// File: rtl/xyz_mem_test_master.sv
// Avalon-MM memory self-test master: fills a word range with a pattern, reads it back, counts mismatches.
// Define XYZ_MEMTEST_LFSR_EN to generate the pattern with a 32-bit Galois LFSR instead of seed+i.
module xyz_mem_test_master #(
  parameter int MEM_DEPTH = 10000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [13:0] i_base_addr,
  input  logic [13:0] i_word_count,
  input  logic [31:0] i_seed,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_error_count,
  output logic [13:0] o_first_err_addr,
  output logic [13:0] o_mem_address,
  output logic [3:0]  o_mem_byteenable,
  output logic        o_mem_chipselect,
  output logic        o_mem_write,
  output logic [31:0] o_mem_writedata,
  output logic        o_mem_clken,
  input  logic [31:0] i_mem_readdata
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  localparam logic [13:0] LAST_ADDR = 14'(MEM_DEPTH - 1);

  function automatic logic [31:0] f_first_pat(input logic [31:0] s);
`ifdef XYZ_MEMTEST_LFSR_EN
    return (s == 32'h0) ? 32'h1 : s;
`else
    return s;
`endif
  endfunction

  function automatic logic [31:0] f_next_pat(input logic [31:0] p);
`ifdef XYZ_MEMTEST_LFSR_EN
    return {1'b0, p[31:1]} ^ (p[0] ? 32'h8020_0003 : 32'h0);
`else
    return p + 32'd1;
`endif
  endfunction

  function automatic logic [13:0] f_next_addr(input logic [13:0] a);
    return (a == LAST_ADDR) ? 14'd0 : a + 14'd1;
  endfunction

  logic [1:0]  r_state;
  logic [13:0] r_base;
  logic [13:0] r_n;
  logic [31:0] r_seed;
  logic [13:0] r_idx;
  logic [13:0] r_addr;
  logic [31:0] r_data;
  logic        r_cs;
  logic        r_we;
  logic        r_done;
  logic [15:0] r_err;
  logic [13:0] r_first;
  logic        r_cmp_valid;
  logic [31:0] r_cmp_exp;
  logic [13:0] r_cmp_addr;
  logic        w_mismatch;

  // r_idx counts accesses issued so far in the current phase, including the one on the bus
  assign w_mismatch = r_cmp_valid && (i_mem_readdata != r_cmp_exp);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_base      <= '0;
      r_n         <= '0;
      r_seed      <= '0;
      r_idx       <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_cs        <= 1'b0;
      r_we        <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= '0;
      r_first     <= '0;
      r_cmp_valid <= 1'b0;
      r_cmp_exp   <= '0;
      r_cmp_addr  <= '0;
    end else begin
      r_cmp_valid <= (r_state == ST_READ);
      r_cmp_exp   <= r_data;
      r_cmp_addr  <= r_addr;

      if (w_mismatch) begin
        if (r_err != 16'hFFFF) r_err <= r_err + 16'd1;
        if (r_err == 16'd0)    r_first <= r_cmp_addr;
      end

      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_done  <= (i_word_count == 14'd0);
            r_err   <= '0;
            r_first <= '0;
            r_base  <= i_base_addr;
            r_n     <= i_word_count;
            r_seed  <= i_seed;
            if (i_word_count != 14'd0) begin
              r_state <= ST_WRITE;
              r_addr  <= i_base_addr;
              r_data  <= f_first_pat(i_seed);
              r_cs    <= 1'b1;
              r_we    <= 1'b1;
              r_idx   <= 14'd1;
            end
          end
        end
        ST_WRITE: begin
          if (r_idx == r_n) begin
            r_state <= ST_READ;
            r_addr  <= r_base;
            r_data  <= f_first_pat(r_seed);
            r_we    <= 1'b0;
            r_idx   <= 14'd1;
          end else begin
            r_addr <= f_next_addr(r_addr);
            r_data <= f_next_pat(r_data);
            r_idx  <= r_idx + 14'd1;
          end
        end
        ST_READ: begin
          if (r_idx == r_n) begin
            r_state <= ST_FLUSH;
            r_cs    <= 1'b0;
            r_we    <= 1'b0;
          end else begin
            r_addr <= f_next_addr(r_addr);
            r_data <= f_next_pat(r_data);
            r_idx  <= r_idx + 14'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b1;
        end
      endcase
    end
  end

  assign o_busy           = (r_state != ST_IDLE);
  assign o_done           = r_done;
  assign o_error_count    = r_err;
  assign o_first_err_addr = r_first;
  assign o_mem_address    = r_addr;
  assign o_mem_byteenable = 4'hF;
  assign o_mem_chipselect = r_cs;
  assign o_mem_write      = r_we;
  assign o_mem_writedata  = r_data;
  assign o_mem_clken      = 1'b1;

endmodule

// File: tb/tb_xyz_mem_test_master.sv
// Bench for xyz_mem_test_master: ideal one-cycle-latency memory model with optional read-bit fault injection.
module tb_xyz_mem_test_master;

  localparam int D = 10000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [13:0] base_addr;
  logic [13:0] word_count;
  logic [31:0] seed;
  logic        busy, done;
  logic [15:0] error_count;
  logic [13:0] first_err_addr, mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata, mem_readdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem [0:D-1];
  bit          f_one, f_all;
  logic [13:0] f_addr;

  always #5 clk = ~clk;

  xyz_mem_test_master #(.MEM_DEPTH(D)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_base_addr(base_addr),
    .i_word_count(word_count), .i_seed(seed), .o_busy(busy), .o_done(done),
    .o_error_count(error_count), .o_first_err_addr(first_err_addr),
    .o_mem_address(mem_address), .o_mem_byteenable(mem_byteenable),
    .o_mem_chipselect(mem_chipselect), .o_mem_write(mem_write),
    .o_mem_writedata(mem_writedata), .o_mem_clken(mem_clken),
    .i_mem_readdata(mem_readdata)
  );

  // Memory model: registered read, fault injection flips bit 0 of read data only
  always @(posedge clk) begin
    if (mem_chipselect && mem_write)
      mem[mem_address] <= mem_writedata;
    if (mem_chipselect && !mem_write)
      mem_readdata <= mem[mem_address] ^ {31'b0, (f_all || (f_one && mem_address == f_addr))};
  end

  function automatic logic [31:0] model_pat(input logic [31:0] s, input int i);
    logic [31:0] p;
`ifdef XYZ_MEMTEST_LFSR_EN
    p = (s == 32'h0) ? 32'h1 : s;
    for (int k = 0; k < i; k++) p = (p >> 1) ^ (p[0] ? 32'h8020_0003 : 32'h0);
`else
    p = s + 32'(i);
`endif
    return p;
  endfunction

  function automatic logic [13:0] wrap_addr(input logic [13:0] b, input int i);
    return 14'((int'(b) + i) % D);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [13:0] base;
    logic [13:0] n;
    logic [31:0] seed;
    bit          fault_one;
    logic [13:0] fault_addr;
    bit          fault_all;
    int          glitch_at;
    logic [15:0] exp_err;
    logic [13:0] exp_first;
  } vec_t;

  task automatic run_vec(input vec_t v, input int id);
    int cyc, busy_cyc, cs_cyc;
    bit got_done;
    logic [13:0] waddr [$];
    f_one = v.fault_one; f_addr = v.fault_addr; f_all = v.fault_all;
    @(negedge clk);
    base_addr = v.base; word_count = v.n; seed = v.seed; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; busy_cyc = 0; cs_cyc = 0; got_done = 0;
    while (!got_done && cyc < 40000) begin
      if (cyc == 0 && v.n != 0) begin
        check($sformatf("v%0d first_we", id), 32'(mem_write), 32'd1);
        check($sformatf("v%0d first_data", id), mem_writedata, model_pat(v.seed, 0));
      end
      if (busy) busy_cyc++;
      if (mem_chipselect) cs_cyc++;
      if (mem_chipselect && mem_write) waddr.push_back(mem_address);
      if (done) got_done = 1;
      if (cyc == v.glitch_at) begin
        start = 1'b1; base_addr = 14'd0; word_count = 14'd1; seed = ~v.seed;
      end else begin
        start = 1'b0;
      end
      cyc++;
      if (!got_done) @(negedge clk);
    end
    start = 1'b0;
    check($sformatf("v%0d done", id), 32'(got_done), 32'd1);
    check($sformatf("v%0d busy_end", id), 32'(busy), 32'd0);
    check($sformatf("v%0d busy_cycles", id), 32'(busy_cyc), (v.n == 0) ? 32'd0 : 32'(2 * int'(v.n) + 1));
    check($sformatf("v%0d cs_cycles", id), 32'(cs_cyc), 32'(2 * int'(v.n)));
    check($sformatf("v%0d error_count", id), 32'(error_count), 32'(v.exp_err));
    check($sformatf("v%0d first_err_addr", id), 32'(first_err_addr), 32'(v.exp_first));
    check($sformatf("v%0d n_writes", id), 32'(waddr.size()), 32'(v.n));
    for (int i = 0; i < waddr.size() && i < int'(v.n); i++)
      check($sformatf("v%0d waddr%0d", id, i), 32'(waddr[i]), 32'(wrap_addr(v.base, i)));
    for (int i = 0; i < int'(v.n); i++)
      check($sformatf("v%0d mem%0d", id, i), mem[wrap_addr(v.base, i)], model_pat(v.seed, i));
    $display("vec %0d: base=%0d n=%0d seed=%h busy_cycles=%0d cs_cycles=%0d err=%0d first=%0d",
             id, v.base, v.n, v.seed, busy_cyc, cs_cyc, error_count, first_err_addr);
  endtask

  vec_t vecs [8];
  vec_t post;

  initial begin
    vecs[0] = '{14'd0,    14'd16, 32'h1000_0000, 0, 14'd0,   0, -1, 16'd0, 14'd0};
    vecs[1] = '{14'd100,  14'd8,  32'hA5A5_0000, 1, 14'd103, 0, -1, 16'd1, 14'd103};
    vecs[2] = '{14'd9998, 14'd4,  32'h0000_0007, 0, 14'd0,   0, -1, 16'd0, 14'd0};
    vecs[3] = '{14'd42,   14'd0,  32'h1234_5678, 0, 14'd0,   0, -1, 16'd0, 14'd0};
    vecs[4] = '{14'd500,  14'd5,  32'hFFFF_FFFE, 0, 14'd0,   1, -1, 16'd5, 14'd500};
    vecs[5] = '{14'd9999, 14'd3,  32'h0BAD_F00D, 1, 14'd1,   0, -1, 16'd1, 14'd1};
    vecs[6] = '{14'd200,  14'd16, 32'hCAFE_0000, 0, 14'd0,   0, 4,  16'd0, 14'd0};
    vecs[7] = '{14'd50,   14'd4,  32'h0000_0000, 0, 14'd0,   0, -1, 16'd0, 14'd0};
    post    = '{14'd700,  14'd4,  32'h0000_0100, 0, 14'd0,   0, -1, 16'd0, 14'd0};

    f_one = 0; f_all = 0; f_addr = '0;
    reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; seed = '0;
    repeat (3) @(negedge clk);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst error_count", 32'(error_count), 32'd0);
    check("rst first_err_addr", 32'(first_err_addr), 32'd0);
    check("rst chipselect", 32'(mem_chipselect), 32'd0);
    check("rst write", 32'(mem_write), 32'd0);
    check("rst address", 32'(mem_address), 32'd0);
    check("rst writedata", mem_writedata, 32'd0);
    check("rst byteenable", 32'(mem_byteenable), 32'hF);
    check("rst clken", 32'(mem_clken), 32'd1);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

`ifdef XYZ_MEMTEST_LFSR_EN
    check("lfsr word0", mem[50], 32'h0000_0001);
    check("lfsr word1", mem[51], 32'h8020_0003);
`else
    check("count word0", mem[50], 32'h0000_0000);
    check("count word1", mem[51], 32'h0000_0001);
`endif

    // Reset in the fifth write cycle of a 16-word run
    @(negedge clk);
    base_addr = 14'd300; word_count = 14'd16; seed = 32'h5555_0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst in_write", 32'(mem_chipselect && mem_write), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst chipselect", 32'(mem_chipselect), 32'd0);
    check("midrst error_count", 32'(error_count), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("postrst idle_cs%0d", i), 32'(mem_chipselect), 32'd0);
    end
    $display("reset mid-write: busy=%0d done=%0d cs=%0d", busy, done, mem_chipselect);
    run_vec(post, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/xyz_mem_test_master.md
# xyz_mem_test_master

Avalon-MM master that drives the single-port on-chip memory slave (14-bit word address, 32-bit data, byteenable, chipselect, write, clken, one-cycle read latency). On `start` it fills a word range with a generated pattern, reads the range back with one read issued per cycle, and reports mismatches. It sits beside the Nios II data master on the same memory slave and provides hardware memory self-test at bring-up.

## Interface
- `MEM_DEPTH`, 10000, number of words in the slave; addresses wrap from `MEM_DEPTH-1` to 0.
- `clk` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: level sampled in IDLE only.
- `base_addr` in 14: first word address; must be < `MEM_DEPTH`.
- `word_count` in 14: words to test (N); 0 is legal.
- `seed` in 32: pattern seed.
- `busy` out 1: test in progress.
- `done` out 1: sticky completion flag; cleared by the next accepted `start`.
- `error_count` out 16: mismatches; saturates at 16'hFFFF.
- `first_err_addr` out 14: address of the first mismatch; valid when `error_count != 0`.
- `mem_address` out 14, `mem_byteenable` out 4, `mem_chipselect` out 1, `mem_write` out 1, `mem_writedata` out 32, `mem_clken` out 1: master side of the memory slave.
- `mem_readdata` in 32: slave read data, valid one cycle after a read is issued.

## Operation
- States:
  - IDLE -> WRITE on `start` with N>0.
  - IDLE -> IDLE with `done`=1 on `start` with N=0, issuing no accesses.
  - WRITE -> READ after N writes.
  - READ -> FLUSH after N reads.
  - FLUSH -> IDLE with `done`=1.
- Latched at the accepted `start`: `base_addr`, `word_count`, `seed`. On the same edge `error_count`, `first_err_addr` and `done` clear. `start` while busy is ignored.
- WRITE: one write per cycle.
  - `mem_chipselect`=1, `mem_write`=1, `mem_byteenable`=4'hF.
  - Address = base+i with wrap; `mem_writedata`=P(i).
- READ: one read per cycle, same address sequence, `mem_chipselect`=1, `mem_write`=0. Pattern generator restarts from P(0).
- Compare pipeline:
  - The expected value and address are registered alongside each read.
  - `mem_readdata` is compared in the following cycle; FLUSH covers the last compare.
  - On mismatch, `error_count` increments (saturating). On the first mismatch only, `first_err_addr` captures the address.
- Pattern P(i) defaults to `seed + i`, mod 2^32.
- `mem_clken` is constant 1. Outside WRITE/READ: `mem_chipselect`=0, `mem_write`=0.
- Reset at any point:
  - Returns to IDLE with all outputs at their reset values.
  - No further accesses are issued after the reset edge.
  - Memory contents are not restored.

## Timing
- Reset values: `busy`=0, `done`=0, `error_count`=0, `first_err_addr`=0, `mem_chipselect`=0, `mem_write`=0, `mem_address`=0, `mem_writedata`=0, `mem_byteenable`=4'hF, `mem_clken`=1.
- `start` sampled at edge E0 (N>0):
  - First write is driven in the cycle after E0.
  - Writes occupy N cycles, immediately followed by N read cycles with no gap.
  - One FLUSH cycle follows.
  - `busy` is high for exactly 2N+1 cycles.
  - `done` rises on the same edge that `busy` falls.
- N=0: `done`=1 in the cycle after E0; `busy` never asserts.
- The read issued in cycle k has its data compared in cycle k+1. `error_count` reflects the compare in cycle k+2.
- Address wrap: after address `MEM_DEPTH-1`, the next address is 0 in the same cadence, with no bubble.
- Saturation: `error_count` holds at 16'hFFFF with no wrap.

## Configuration
- `XYZ_MEMTEST_LFSR_EN` defined:
  - P(0)=`seed`, with a seed of 0 replaced by 32'h1.
  - P(i+1) = (P(i)>>1) ^ (P(i)[0] ? 32'h80200003 : 0), a Galois LFSR.
  - The same sequence is regenerated in READ.
- Not defined: P(i)=`seed+i`. No LFSR logic is present.

## Test plan
- Clean run: base=0, N=16, seed=32'h1000_0000 with an ideal memory model -> words 0..15 hold 32'h1000_0000..32'h1000_000F; `busy` high 33 cycles; `done`=1; `error_count`=0.
- Fault injection: base=100, N=8; the model returns bit 0 flipped at address 103 -> `error_count`=1; `first_err_addr`=103.
- Wrap: base=9998, N=4 -> write addresses 9998, 9999, 0, 1 in consecutive cycles; `error_count`=0.
- N=0 and start-while-busy:
  - N=0 -> `done` next cycle; zero chipselect cycles.
  - A second `start` pulse mid-test -> ignored; counts unchanged.
- Reset mid-WRITE (cycle 5 of N=16) -> next cycle `busy`=0, `done`=0, `mem_chipselect`=0; a subsequent start with N=4 completes clean.
- With `XYZ_MEMTEST_LFSR_EN`, seed=0 -> word 0 = 32'h1, word 1 = 32'h80200003; `error_count`=0.
